// File: rtl/camera_capture_ctrl.sv
// Ping-pong frame capture sequencer: arms on start, aligns to a clean vsync, writes linear addresses.
// Optional 2x decimation (even pixels of even source lines only) when CAPTURE_DECIMATE_EN is defined.
module camera_capture_ctrl #(
  parameter int unsigned H_PIXELS = 320,
  parameter int unsigned V_LINES  = 240,
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              p_clock,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              vsync,
  input  logic              href,
  input  logic              pixel_valid,
  input  logic [DATA_W-1:0] pixel_data,
  input  logic              frame_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_bank,
  output logic              ready_bank,
  output logic              frame_ready,
  output logic              frame_error,
  output logic              busy
);

  localparam int unsigned X_W = $clog2(H_PIXELS + 1);
  localparam int unsigned Y_W = $clog2(V_LINES + 1);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, DONE} state_t;

  state_t              state_q;
  logic [X_W-1:0]      x_q;
  logic [Y_W-1:0]      y_q;
  logic [ADDR_W-1:0]   base_q;
  logic                ovf_q;
  logic                short_q;
  logic                seen_vs_q;
  logic                href_q;
  logic                wr_en_q;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [DATA_W-1:0]   wr_data_q;
  logic                wr_bank_q;
  logic                ready_bank_q;
  logic                frame_ready_q;
  logic                frame_error_q;
  logic                busy_q;

  logic                keep_px_c;
  logic                line_end_c;
  logic                x_room_c;
  logic                y_room_c;

`ifdef CAPTURE_DECIMATE_EN
  logic                px_par_q;
  logic                py_par_q;
  assign keep_px_c = pixel_valid && !px_par_q && !py_par_q;
`else
  assign keep_px_c = pixel_valid;
`endif

  assign line_end_c = href_q && !href;
  assign x_room_c   = x_q < X_W'(H_PIXELS);
  assign y_room_c   = y_q < Y_W'(V_LINES);

  always_ff @(posedge p_clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      base_q        <= '0;
      ovf_q         <= 1'b0;
      short_q       <= 1'b0;
      seen_vs_q     <= 1'b0;
      href_q        <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      wr_bank_q     <= 1'b0;
      ready_bank_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
      px_par_q      <= 1'b0;
      py_par_q      <= 1'b0;
`endif
    end else begin
      wr_en_q       <= 1'b0;
      frame_ready_q <= 1'b0;
      href_q        <= href;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q       <= SYNC;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b1;
            seen_vs_q     <= 1'b0;
          end
        end
        // Only a full blank-to-active vsync transition opens a capture window.
        SYNC: begin
          if (vsync) begin
            seen_vs_q <= 1'b1;
          end else if (seen_vs_q) begin
            state_q <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (keep_px_c) begin
            if (x_room_c && y_room_c) begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= base_q + ADDR_W'(x_q);
              wr_data_q <= pixel_data;
              x_q       <= x_q + X_W'(1);
            end else begin
              ovf_q <= 1'b1;
            end
          end
`ifdef CAPTURE_DECIMATE_EN
          if (pixel_valid) px_par_q <= ~px_par_q;
          if (line_end_c) begin
            px_par_q <= 1'b0;
            py_par_q <= ~py_par_q;
          end
`endif
          // Stored x is only non-zero on kept lines, so skipped lines never advance y/base.
          if (line_end_c && (x_q != '0)) begin
            if (x_q != X_W'(H_PIXELS)) short_q <= 1'b1;
            base_q <= base_q + ADDR_W'(H_PIXELS);
            y_q    <= y_q + Y_W'(1);
            x_q    <= '0;
          end
          if (frame_done || vsync) state_q <= DONE;
        end
        DONE: begin
          if ((y_q == Y_W'(V_LINES)) && !ovf_q && !short_q) begin
            frame_ready_q <= 1'b1;
            ready_bank_q  <= wr_bank_q;
            wr_bank_q     <= ~wr_bank_q;
          end else begin
            frame_error_q <= 1'b1;
          end
          x_q       <= '0;
          y_q       <= '0;
          base_q    <= '0;
          ovf_q     <= 1'b0;
          short_q   <= 1'b0;
          seen_vs_q <= 1'b0;
`ifdef CAPTURE_DECIMATE_EN
          px_par_q  <= 1'b0;
          py_par_q  <= 1'b0;
`endif
          if (continuous) begin
            state_q <= SYNC;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_bank     = wr_bank_q;
  assign ready_bank  = ready_bank_q;
  assign frame_ready = frame_ready_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: doc/camera_capture_ctrl.md
Name: camera_capture_ctrl

Overview:
Sequences frame capture from the camera pixel assembler into a dual-bank (ping-pong) frame buffer. It arms on request and aligns to a clean frame start. It generates linear write addresses from pixel/line counters, checks frame geometry, then hands the completed bank to the display side. It sits between the camera pixel assembler outputs and the BRAM write port, on the camera pixel clock.

Parameters:
H_PIXELS, 320, stored pixels per line
V_LINES, 240, stored lines per frame
ADDR_W, 17, write address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES
DATA_W, 16, pixel word width

Ports:
p_clock  in  1  camera pixel clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request: arm capture
continuous  in  1  1 = re-arm automatically after each frame; sampled at DONE
vsync  in  1  camera vsync (high = vertical blank)
href  in  1  camera line-valid
pixel_valid  in  1  assembled pixel strobe
pixel_data  in  DATA_W  assembled pixel
frame_done  in  1  end-of-frame pulse from assembler
wr_en  out  1  frame buffer write enable
wr_addr  out  ADDR_W  write address within bank
wr_data  out  DATA_W  write data
wr_bank  out  1  bank being written
ready_bank  out  1  bank holding last good frame
frame_ready  out  1  one-cycle pulse: good frame committed
frame_error  out  1  sticky geometry error; cleared on start
busy  out  1  high in any state but IDLE

Behaviour:
- Reset values: every output 0; state IDLE; counters 0.
- States: IDLE, SYNC, CAPTURE, DONE.
- IDLE: on start -> SYNC; clear frame_error.
- SYNC: wait for vsync=1, then vsync=0 -> CAPTURE. A capture armed mid-frame never writes a partial frame.
- CAPTURE write path:
  - On pixel_valid with x < H_PIXELS and y < V_LINES: next cycle wr_en=1, wr_addr=base+x, wr_data=pixel_data; x++.
  - Latency: exactly 1 cycle.
  - Pixels with x >= H_PIXELS, or lines with y >= V_LINES: no write; set overflow flag.
- Line end:
  - Falling edge of href (registered previous href) with x > 0: base += H_PIXELS; y++; x=0.
  - If x != H_PIXELS at that edge, set short-line flag.
  - Address is computed incrementally; no multiplier.
- Frame end: frame_done=1 or vsync=1 in CAPTURE -> DONE.
  - pixel_valid in the same cycle is still written.
- DONE (one cycle):
  - Good frame (y == V_LINES and no flags): frame_ready=1; ready_bank<=wr_bank; wr_bank toggles.
  - Otherwise: frame_error=1; banks unchanged; bad bank is overwritten by the next capture.
  - Clear x, y, base, flags.
  - continuous=1 -> SYNC; else -> IDLE.
- start outside IDLE is ignored.
- Reset asserted mid-capture: immediate return to reset values; ready_bank returns to 0.
- wr_en is never asserted outside CAPTURE, apart from the single trailing registered write.

Optional Feature:
CAPTURE_DECIMATE_EN
- Defined: 2x decimation. Only even-indexed source pixels of even-indexed source lines are written.
  - Source pixel/line parity counters run alongside x/y.
  - H_PIXELS/V_LINES denote stored (decimated) size.
  - Line-end checks use stored x.
  - Odd lines advance only the parity counter, not y/base.
- Undefined: every valid pixel is a write candidate. No parity logic is synthesized.

Test Plan:
- H_PIXELS=4, V_LINES=3, start with vsync=0 mid-frame -> no write until vsync rises then falls. Then 3 lines x 4 pixels produce wr_addr 0..11 in order, wr_bank=0, wr_data matching inputs with 1-cycle latency. Then frame_ready pulses once, ready_bank=0, wr_bank=1.
- Same setup, continuous=1, two frames -> second frame writes addr 0..11 with wr_bank=1; after it ready_bank=1 and wr_bank=0.
- Line 1 has 3 pixels -> frame_error=1, no frame_ready, wr_bank unchanged. Next start clears frame_error.
- Line 0 has 6 pixels -> only the first 4 written (addr 0..3); frame_error=1 at DONE.
- Reset pulsed after 5 writes -> wr_en=0, busy=0, all outputs 0 asynchronously. A new start recaptures from addr 0.
- CAPTURE_DECIMATE_EN defined, source 8x6 frame, H_PIXELS=4, V_LINES=3 -> 12 writes addr 0..11 carrying source pixels (0,0),(0,2),(0,4),(0,6),(2,0),… Then frame_ready pulses.
